// File: rtl/mul_iter_u_if.sv
// Operand/result handshake bundle for mul_iter_u.
// p_hi is present only when MUL_ITER_HI_EN is defined.
interface mul_iter_u_if #(
    parameter int W = 64
) ();
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] p_lo;
`ifdef MUL_ITER_HI_EN
    logic [W-1:0] p_hi;

    modport slave (
        input  flush, in_valid, x, y, out_ready,
        output in_ready, out_valid, p_lo, p_hi
    );

    modport master (
        output flush, in_valid, x, y, out_ready,
        input  in_ready, out_valid, p_lo, p_hi
    );
`else
    modport slave (
        input  flush, in_valid, x, y, out_ready,
        output in_ready, out_valid, p_lo
    );

    modport master (
        output flush, in_valid, x, y, out_ready,
        input  in_ready, out_valid, p_lo
    );
`endif
endinterface

// File: rtl/mul_iter_u.sv
// Iterative unsigned multiplier: W-bit operands are split into N = W/CW chunks
// and one CW x CW partial product is accumulated per cycle through a single
// shared multiplier.
// Build option MUL_ITER_HI_EN: compute all N*N partial products, keep a 2W-bit
// accumulator and expose the upper product half on p_hi. Without it only the
// pairs that can reach the low W bits are computed.
//
// state  | meaning
// S_IDLE | ready for operands, in_ready=1
// S_CALC | one partial product accumulated per cycle
// S_DONE | result presented, waiting for out_ready
module mul_iter_u #(
    parameter int W  = 64,
    parameter int CW = 32
) (
    input  logic         clk,
    input  logic         rstb,
    mul_iter_u_if.slave  bus
);

    localparam int N  = W / CW;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
`ifdef MUL_ITER_HI_EN
    localparam int AW = 2 * W;
`else
    localparam int AW = W;
`endif
    // Product width actually needed: bits above the accumulator would be dropped anyway.
    localparam int PPW = (2 * CW < AW) ? 2 * CW : AW;

    if (CW < 1 || CW > W || (W % CW) != 0) begin : g_param_err
        $error("mul_iter_u: CW must divide W and satisfy 1 <= CW <= W");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    x_r;
    logic [W-1:0]    y_r;
    logic [AW-1:0]   acc;
    logic [AW-1:0]   acc_nxt;
    logic [IW-1:0]   i;
    logic [IW-1:0]   j;
    logic [IW-1:0]   i_nxt;
    logic [IW-1:0]   j_nxt;
    logic [W-1:0]    p_lo_r;
`ifdef MUL_ITER_HI_EN
    logic [W-1:0]    p_hi_r;
`endif
    logic            accept;
    logic            last_i;
    logic            last_j;
    logic            last_pair;
    logic [CW-1:0]   x_chunk;
    logic [CW-1:0]   y_chunk;
    logic [PPW-1:0]  pp;
    logic [AW-1:0]   pp_ext;

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.p_lo      = p_lo_r;
`ifdef MUL_ITER_HI_EN
    assign bus.p_hi      = p_hi_r;
`endif

    // Inner-loop end: full mode sweeps all i; low mode stops once i+j reaches N-1.
`ifdef MUL_ITER_HI_EN
    assign last_i = (i == IW'(N - 1));
`else
    assign last_i = (({1'b0, i} + {1'b0, j}) == (IW + 1)'(N - 1));
`endif
    assign last_j    = (j == IW'(N - 1));
    assign last_pair = last_i && last_j;

    // Shared multiplier and shifted accumulate for the current (i, j) pair.
    always_comb begin
        x_chunk = CW'(x_r >> (CW * int'(i)));
        y_chunk = CW'(y_r >> (CW * int'(j)));
        pp      = PPW'(x_chunk) * PPW'(y_chunk);
        pp_ext  = AW'(pp);
        acc_nxt = acc + (pp_ext << (CW * (int'(i) + int'(j))));
    end

    // State register.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and chunk-index sequencing; flush overrides everything.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        i_nxt     = i;
        j_nxt     = j;
        case (state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_CALC;
                    i_nxt     = '0;
                    j_nxt     = '0;
                end
            end
            S_CALC: begin
                if (last_i) begin
                    i_nxt = '0;
                    if (last_j) begin
                        j_nxt     = '0;
                        state_nxt = S_DONE;
                    end else begin
                        j_nxt = j + 1'b1;
                    end
                end else begin
                    i_nxt = i + 1'b1;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (bus.flush) begin
            state_nxt = S_IDLE;
            accept    = 1'b0;
            i_nxt     = '0;
            j_nxt     = '0;
        end
    end

    // Operand capture, accumulation and result registers.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            x_r    <= '0;
            y_r    <= '0;
            acc    <= '0;
            i      <= '0;
            j      <= '0;
            p_lo_r <= '0;
`ifdef MUL_ITER_HI_EN
            p_hi_r <= '0;
`endif
        end else begin
            i <= i_nxt;
            j <= j_nxt;
            if (accept) begin
                x_r <= bus.x;
                y_r <= bus.y;
                acc <= '0;
            end else if (state == S_CALC && !bus.flush) begin
                acc <= acc_nxt;
                if (last_pair) begin
                    p_lo_r <= acc_nxt[W-1:0];
`ifdef MUL_ITER_HI_EN
                    p_hi_r <= acc_nxt[2*W-1:W];
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_iter_u.sv
// Directed bench for mul_iter_u: a 64/32 instance for the handshake, hold,
// flush and reset scenarios, and a 16/4 instance for a large operand sweep.
module tb_mul_iter_u;

`ifdef MUL_ITER_HI_EN
    localparam int K64 = 4;
    localparam int K16 = 16;
`else
    localparam int K64 = 3;
    localparam int K16 = 10;
`endif

    logic clk = 1'b0;
    logic rstb = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mul_iter_u_if #(.W(64)) bus64 ();
    mul_iter_u_if #(.W(16)) bus16 ();

    mul_iter_u #(.W(64), .CW(32)) dut64 (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus64)
    );

    mul_iter_u #(.W(16), .CW(4)) dut16 (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus16)
    );

    always #5 clk = ~clk;

    task automatic run64(input logic [63:0] a, input logic [63:0] b,
                         output int lat, output logic [63:0] lo, output logic [63:0] hi);
        int guard;
        guard = 0;
        while (bus64.in_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        bus64.x = a;
        bus64.y = b;
        bus64.in_valid = 1'b1;
        @(posedge clk); #1;
        bus64.in_valid = 1'b0;
        bus64.x = ~a;
        bus64.y = 64'h5A5A_A5A5_3C3C_C3C3;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (bus64.out_valid !== 1'b1 && lat < 100);
        lo = bus64.p_lo;
        hi = '0;
`ifdef MUL_ITER_HI_EN
        hi = bus64.p_hi;
`endif
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b,
                         output int lat, output logic [15:0] lo, output logic [15:0] hi);
        int guard;
        guard = 0;
        while (bus16.in_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        bus16.x = a;
        bus16.y = b;
        bus16.in_valid = 1'b1;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        bus16.x = ~b;
        bus16.y = ~a;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (bus16.out_valid !== 1'b1 && lat < 100);
        lo = bus16.p_lo;
        hi = '0;
`ifdef MUL_ITER_HI_EN
        hi = bus16.p_hi;
`endif
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (bus64.in_ready !== 1'b1 || bus64.out_valid !== 1'b0 || bus64.p_lo !== 64'h0) begin
            errors++;
            $display("FAIL reset64 got rdy=%b vld=%b lo=%h exp 1 0 0",
                     bus64.in_ready, bus64.out_valid, bus64.p_lo);
        end
`ifdef MUL_ITER_HI_EN
        checks++;
        if (bus64.p_hi !== 64'h0) begin
            errors++;
            $display("FAIL reset64_hi got %h exp 0", bus64.p_hi);
        end
`endif
        checks++;
        if (bus16.in_ready !== 1'b1 || bus16.out_valid !== 1'b0 || bus16.p_lo !== 16'h0) begin
            errors++;
            $display("FAIL reset16 got rdy=%b vld=%b lo=%h exp 1 0 0",
                     bus16.in_ready, bus16.out_valid, bus16.p_lo);
        end
        @(negedge clk);
        rstb = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_all_ones();
        int lat;
        logic [63:0] lo, hi;
        bus64.out_ready = 1'b1;
        run64(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, lat, lo, hi);
        checks++;
        if (lat !== K64) begin
            errors++;
            $display("FAIL ones_latency got %0d exp %0d", lat, K64);
        end
        checks++;
        if (lo !== 64'h0000_0000_0000_0001) begin
            errors++;
            $display("FAIL ones_lo got %h exp 0000000000000001", lo);
        end
`ifdef MUL_ITER_HI_EN
        checks++;
        if (hi !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            errors++;
            $display("FAIL ones_hi got %h exp fffffffffffffffe", hi);
        end
`endif
        @(posedge clk); #1;
        checks++;
        if (bus64.out_valid !== 1'b0 || bus64.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ones_handshake got vld=%b rdy=%b exp 0 1", bus64.out_valid, bus64.in_ready);
        end
    endtask

    task automatic test_cross_chunk();
        int lat;
        logic [63:0] lo, hi;
        run64(64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, lat, lo, hi);
        checks++;
        if (lo !== 64'h0) begin
            errors++;
            $display("FAIL cross_lo got %h exp 0", lo);
        end
`ifdef MUL_ITER_HI_EN
        checks++;
        if (hi !== 64'h1) begin
            errors++;
            $display("FAIL cross_hi got %h exp 1", hi);
        end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_hold_and_back_to_back();
        int lat;
        logic [63:0] lo, hi;
        bus64.out_ready = 1'b0;
        run64(64'h0000_0000_DEAD_BEEF, 64'h0000_0000_0000_0010, lat, lo, hi);
        checks++;
        if (lo !== 64'h0000_000D_EADB_EEF0 || lat !== K64) begin
            errors++;
            $display("FAIL hold_first got lo=%h lat=%0d exp 0000000deadbeef0 %0d", lo, lat, K64);
        end
        bus64.x = 64'h9;
        bus64.y = 64'h9;
        bus64.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (bus64.out_valid !== 1'b1 || bus64.in_ready !== 1'b0 || bus64.p_lo !== 64'h0000_000D_EADB_EEF0) begin
                errors++;
                $display("FAIL hold_cycle%0d got vld=%b rdy=%b lo=%h exp 1 0 0000000deadbeef0",
                         c, bus64.out_valid, bus64.in_ready, bus64.p_lo);
            end
        end
        bus64.in_valid = 1'b0;
        bus64.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus64.out_valid !== 1'b0 || bus64.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release got vld=%b rdy=%b exp 0 1", bus64.out_valid, bus64.in_ready);
        end
        run64(64'h0000_0000_0000_1234, 64'h0000_0000_0000_0010, lat, lo, hi);
        checks++;
        if (lo !== 64'h0000_0000_0001_2340 || lat !== K64) begin
            errors++;
            $display("FAIL back_to_back got lo=%h lat=%0d exp 0000000000012340 %0d", lo, lat, K64);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        int lat;
        logic seen;
        logic [63:0] lo, hi;
        bus64.out_ready = 1'b1;
        bus64.x = 64'd3;
        bus64.y = 64'd5;
        bus64.in_valid = 1'b1;
        @(posedge clk); #1;
        bus64.in_valid = 1'b0;
        bus64.flush = 1'b1;
        @(posedge clk); #1;
        bus64.flush = 1'b0;
        checks++;
        if (bus64.in_ready !== 1'b1 || bus64.out_valid !== 1'b0 || bus64.p_lo !== 64'h0000_0000_0001_2340) begin
            errors++;
            $display("FAIL flush_abort got rdy=%b vld=%b lo=%h exp 1 0 0000000000012340",
                     bus64.in_ready, bus64.out_valid, bus64.p_lo);
        end
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus64.out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_valid got %b exp 0", seen);
        end
        bus64.x = 64'd9;
        bus64.y = 64'd9;
        bus64.in_valid = 1'b1;
        bus64.flush = 1'b1;
        @(posedge clk); #1;
        bus64.in_valid = 1'b0;
        bus64.flush = 1'b0;
        checks++;
        if (bus64.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_over_accept got rdy=%b exp 1", bus64.in_ready);
        end
        run64(64'd7, 64'd6, lat, lo, hi);
        checks++;
        if (lo !== 64'd42 || lat !== K64) begin
            errors++;
            $display("FAIL flush_next_op got lo=%0d lat=%0d exp 42 %0d", lo, lat, K64);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_calc();
        int lat;
        logic [63:0] lo, hi;
        bus64.out_ready = 1'b1;
        bus64.x = 64'h1111_2222_3333_4444;
        bus64.y = 64'h5555_6666_7777_8888;
        bus64.in_valid = 1'b1;
        @(posedge clk); #1;
        bus64.in_valid = 1'b0;
        @(posedge clk); #2;
        rstb = 1'b0;
        #1;
        checks++;
        if (bus64.in_ready !== 1'b1 || bus64.out_valid !== 1'b0 || bus64.p_lo !== 64'h0) begin
            errors++;
            $display("FAIL async_reset got rdy=%b vld=%b lo=%h exp 1 0 0",
                     bus64.in_ready, bus64.out_valid, bus64.p_lo);
        end
        @(negedge clk);
        rstb = 1'b1;
        @(posedge clk); #1;
        run64(64'h0000_0001_0000_0001, 64'h0000_0000_FFFF_FFFF, lat, lo, hi);
        checks++;
        if (lo !== 64'hFFFF_FFFF_FFFF_FFFF || lat !== K64) begin
            errors++;
            $display("FAIL post_reset got lo=%h lat=%0d exp ffffffffffffffff %0d", lo, lat, K64);
        end
`ifdef MUL_ITER_HI_EN
        checks++;
        if (hi !== 64'h0) begin
            errors++;
            $display("FAIL post_reset_hi got %h exp 0", hi);
        end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_w16_sweep();
        int lat;
        logic [15:0] a, b, lo, hi;
        logic [31:0] full;
        bus16.out_ready = 1'b1;
        for (int n = 0; n < 1002; n++) begin
            if (n == 0) begin
                a = 16'hFFFF;
                b = 16'hFFFF;
            end else if (n == 1) begin
                a = 16'h00F0;
                b = 16'h0F00;
            end else begin
                a = 16'($urandom_range(0, 65535));
                b = 16'($urandom_range(0, 65535));
            end
            full = 32'(a) * 32'(b);
            run16(a, b, lat, lo, hi);
            checks++;
            if (lo !== full[15:0] || lat !== K16) begin
                errors++;
                $display("FAIL w16_lo a=%h b=%h got lo=%h lat=%0d exp %h %0d",
                         a, b, lo, lat, full[15:0], K16);
            end
`ifdef MUL_ITER_HI_EN
            checks++;
            if (hi !== full[31:16]) begin
                errors++;
                $display("FAIL w16_hi a=%h b=%h got %h exp %h", a, b, hi, full[31:16]);
            end
`endif
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bus64.flush = 1'b0;
        bus64.in_valid = 1'b0;
        bus64.out_ready = 1'b1;
        bus64.x = '0;
        bus64.y = '0;
        bus16.flush = 1'b0;
        bus16.in_valid = 1'b0;
        bus16.out_ready = 1'b1;
        bus16.x = '0;
        bus16.y = '0;
        test_reset();
        test_all_ones();
        test_cross_chunk();
        test_hold_and_back_to_back();
        test_flush();
        test_reset_mid_calc();
        test_w16_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
